axi_lite_slave_regfile: RTL
===========================

Name: axi_lite_slave_regfile

Overview:
- AXI4-Lite responder: the target end of the write/read transactions issued by our AXI-Lite master.
- Holds C_NUM_REGS read/write control registers and one read-only status word.
- Control registers drive user logic; the status word is sampled from user logic.
- Sits behind the interconnect and is used as the register bank for SPI-bridge and bench bring-up.

Parameters:
C_S_AXI_ADDR_WIDTH, 32, address width in bits
C_S_AXI_DATA_WIDTH, 32, data width in bits; only 32 is supported
C_NUM_REGS, 8, number of RW registers; range 1..64
C_RESET_VALUE, 32'h0000_0000, reset value of every RW register

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  asynchronous reset, active-high
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWPROT  in  3  accepted and ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARPROT  in  3  accepted and ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_out  out  32*C_NUM_REGS  flattened RW register contents; reg k occupies bits [32k+31:32k]
status_in  in  32  read-only status word
wr_pulse  out  C_NUM_REGS  one-cycle strobe on the commit cycle of the register written

Behaviour:
Reset:
- All registers clear asynchronously.
- All *READY, *VALID, BRESP, RRESP, RDATA and wr_pulse go to 0; every reg_out word goes to C_RESET_VALUE.
- An in-flight transaction is dropped with no response.
- READY signals rise on the first clock edge after reset deasserts.

Address decode:
- idx = ADDR >> 2; bits [1:0] are ignored.
- idx < C_NUM_REGS selects a RW register.
- idx == C_NUM_REGS selects status_in (read-only).
- Any other idx is unmapped.

Write path, FSM WR_IDLE -> WR_COMMIT -> WR_RESP:
- WR_IDLE: AW and W are captured independently into holding regs, each with a "full" flag.
  - AWREADY = !aw_full; WREADY = !w_full.
  - Any arrival order is accepted, including AW and W on the same cycle.
- When both flags are set, go to WR_COMMIT; both READYs are low from then on.
- WR_COMMIT, one cycle:
  - RW target: byte lane i is written iff WSTRB[i]; wr_pulse[idx] = 1; BRESP = 00.
  - Status or unmapped target: no register change, no pulse, BRESP = 10.
  - BRESP is registered and BVALID rises at the edge ending this cycle.
- Latency: if the later handshake completes on edge N, reg_out changes and BVALID rises at edge N+1.
- WR_RESP: hold BVALID and BRESP stable until BREADY is sampled high. On that edge, clear both flags and return to WR_IDLE; READYs rise again on that edge.
- WSTRB = 0 on a valid target returns OKAY with no data change; wr_pulse still fires.
- Throughput is one write per 3 cycles minimum.

Read path, FSM RD_IDLE -> RD_RESP:
- ARREADY = 1 only in RD_IDLE.
- On the ARVALID & ARREADY edge, register RDATA and RRESP from current contents (00, or 10 with RDATA = 0 if unmapped), set RVALID and go to RD_RESP.
- RVALID appears 1 cycle after the handshake edge.
- Hold RDATA, RRESP and RVALID stable until RREADY is sampled high, then return to RD_IDLE.
- Minimum throughput is one read per 2 cycles.

Simultaneous read and write:
- The read and write paths are fully independent.
- If an AR handshake and a write commit hit the same register on the same edge, RDATA returns the pre-write value.

Other rules:
- AWPROT and ARPROT have no effect.
- Only one transaction is outstanding per direction.

Decomposition:
- Package axi_lite_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - ADDR_LSB = 2.
  - The write FSM state encoding and the read FSM state encoding.
- One natural sub-module is axi_lite_regfile_core: the byte-strobed register array with the write port and an asynchronous read mux. The top level keeps the AXI handshake FSMs and the decode.

Test Plan:
1. Write 0xDEADBEEF to 0x04 with STRB=1111 and AW/W on the same cycle -> BVALID at N+1 with BRESP=00; reg_out[1]=0xDEADBEEF; wr_pulse[1] high for one cycle; read 0x04 returns 0xDEADBEEF with RRESP=00.
2. Issue W three cycles before AW (data 0x11223344, STRB=0101, addr 0x00, prior value 0) -> WREADY low while waiting; reg_out[0]=0x00220044 after commit.
3. Write to 0x20 (status, C_NUM_REGS=8) and to 0x40 -> BRESP=10 for both, no reg_out change, wr_pulse stays 0; read 0x20 with status_in=0xA5A5_0001 -> RDATA=0xA5A50001, RRESP=00; read 0x40 -> RDATA=0, RRESP=10.
4. Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and their data stay stable; AWREADY, WREADY and ARREADY stay low until the accepting edge.
5. Same-edge read of reg 2 (old 0x5) and write commit of 0x9 to reg 2 -> RDATA=0x5; a subsequent read returns 0x9.
6. Assert S_AXI_ARESET while BVALID=1 -> BVALID, RVALID and the READYs drop immediately; reg_out returns to C_RESET_VALUE; READYs rise at the first edge after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared constants and FSM encodings for the AXI4-Lite register slave.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned ADDR_LSB = 2;

    typedef enum logic [1:0] {
        WrIdle,
        WrCommit,
        WrResp
    } wr_state_e;

    typedef enum logic [0:0] {
        RdIdle,
        RdResp
    } rd_state_e;

endpackage

// File: rtl/axi_lite_regfile_core.sv
// Byte-strobed RW register array: one synchronous write port, one asynchronous read port.
module axi_lite_regfile_core #(
    parameter int unsigned NumRegs    = 8,
    parameter int unsigned IdxW       = 4,
    parameter logic [31:0] ResetValue = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IdxW-1:0]       wr_idx,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic [IdxW-1:0]       rd_idx,
    output logic [31:0]           rdata,
    output logic [32*NumRegs-1:0] reg_out
);

    logic [31:0] regs_q [NumRegs];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(NumRegs); k++) begin
                regs_q[k] <= ResetValue;
            end
        end else if (we) begin
            for (int k = 0; k < int'(NumRegs); k++) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_idx == IdxW'(k) && wstrb[b]) begin
                        regs_q[k][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < int'(NumRegs); k++) begin
            if (rd_idx == IdxW'(k)) begin
                rdata = regs_q[k];
            end
        end
    end

    for (genvar k = 0; k < int'(NumRegs); k++) begin : g_out
        assign reg_out[32*k +: 32] = regs_q[k];
    end

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave exposing C_NUM_REGS RW control registers plus one read-only status word.
module axi_lite_slave_regfile
    import axi_lite_pkg::*;
#(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_NUM_REGS         = 8,
    parameter logic [31:0] C_RESET_VALUE      = 32'h0000_0000
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [32*C_NUM_REGS-1:0]      reg_out,
    input  logic [31:0]                   status_in,
    output logic [C_NUM_REGS-1:0]         wr_pulse
);

    localparam int unsigned AW   = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned IdxW = $clog2(C_NUM_REGS + 1);
    localparam logic [AW-1:0] NumRegsA = AW'(C_NUM_REGS);

    wr_state_e   wr_state_q;
    logic        aw_full_q, w_full_q;
    logic [AW-1:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        awready_q, wready_q, bvalid_q;
    logic [1:0]  bresp_q;

    rd_state_e   rd_state_q;
    logic        arready_q, rvalid_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q;

    logic        aw_hs, w_hs, aw_full_nxt, w_full_nxt;
    logic [AW-1:0] aw_idx, ar_idx;
    logic        wr_hit_rw, rd_hit_rw, rd_hit_status, core_we;
    logic [31:0] core_rdata, rd_value;
    logic [1:0]  rd_resp;

    always_comb begin
        aw_hs       = S_AXI_AWVALID && awready_q;
        w_hs        = S_AXI_WVALID && wready_q;
        aw_full_nxt = aw_full_q || aw_hs;
        w_full_nxt  = w_full_q || w_hs;
        aw_idx      = aw_addr_q >> ADDR_LSB;
        ar_idx      = S_AXI_ARADDR >> ADDR_LSB;
        wr_hit_rw   = aw_idx < NumRegsA;
        rd_hit_rw   = ar_idx < NumRegsA;
        rd_hit_status = ar_idx == NumRegsA;
        core_we     = (wr_state_q == WrCommit) && wr_hit_rw;
        rd_value    = rd_hit_rw ? core_rdata : (rd_hit_status ? status_in : '0);
        rd_resp     = (rd_hit_rw || rd_hit_status) ? RESP_OKAY : RESP_SLVERR;
    end

    always_comb begin
        wr_pulse = '0;
        for (int k = 0; k < int'(C_NUM_REGS); k++) begin
            wr_pulse[k] = core_we && (aw_idx == AW'(k));
        end
    end

    axi_lite_regfile_core #(
        .NumRegs    (C_NUM_REGS),
        .IdxW       (IdxW),
        .ResetValue (C_RESET_VALUE)
    ) u_core (
        .clk     (S_AXI_ACLK),
        .rst     (S_AXI_ARESET),
        .we      (core_we),
        .wr_idx  (aw_idx[IdxW-1:0]),
        .wdata   (w_data_q),
        .wstrb   (w_strb_q),
        .rd_idx  (ar_idx[IdxW-1:0]),
        .rdata   (core_rdata),
        .reg_out (reg_out)
    );

    // AW and W land independently; commit starts once both holding regs are full.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_state_q <= WrIdle;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            unique case (wr_state_q)
                WrIdle: begin
                    if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
                    if (w_hs) begin
                        w_data_q <= S_AXI_WDATA;
                        w_strb_q <= S_AXI_WSTRB;
                    end
                    aw_full_q <= aw_full_nxt;
                    w_full_q  <= w_full_nxt;
                    if (aw_full_nxt && w_full_nxt) begin
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                        wr_state_q <= WrCommit;
                    end else begin
                        awready_q <= !aw_full_nxt;
                        wready_q  <= !w_full_nxt;
                    end
                end
                WrCommit: begin
                    bvalid_q   <= 1'b1;
                    bresp_q    <= wr_hit_rw ? RESP_OKAY : RESP_SLVERR;
                    wr_state_q <= WrResp;
                end
                WrResp: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q   <= 1'b0;
                        aw_full_q  <= 1'b0;
                        w_full_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        wr_state_q <= WrIdle;
                    end
                end
                default: wr_state_q <= WrIdle;
            endcase
        end
    end

    // Sampling the array here returns the pre-write value on a same-edge commit.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rd_state_q <= RdIdle;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            unique case (rd_state_q)
                RdIdle: begin
                    if (S_AXI_ARVALID && arready_q) begin
                        rdata_q    <= rd_value;
                        rresp_q    <= rd_resp;
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                        rd_state_q <= RdResp;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                RdResp: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= RdIdle;
                    end
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    logic unused;
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr_q[1:0], S_AXI_ARADDR[1:0],
                      aw_idx[AW-1:IdxW], ar_idx[AW-1:IdxW]};

endmodule
